// File: rtl/conv_bias_relu_1x1_pkg.sv
// Shared types and constants for the 1x1 conv bias-add / ReLU stage.
// Default-width saturation limits, FSM encoding and counter-width helper.
package conv_bias_relu_1x1_pkg;

  localparam int unsigned DATA_WIDTH_DEF      = 32;
  localparam int unsigned CHANNEL_NUM_OUT_DEF = 128;
  localparam int unsigned IMAGE_SIZE_DEF      = 1024;

  localparam logic [DATA_WIDTH_DEF-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};
  localparam logic [DATA_WIDTH_DEF-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

  localparam int unsigned PXL_CNT_W_DEF = $clog2(IMAGE_SIZE_DEF);
  localparam int unsigned CH_CNT_W_DEF  = $clog2(CHANNEL_NUM_OUT_DEF);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Counter width that stays legal for a count of one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_bias_relu_1x1_if.sv
// Stream/bias bus between the conv stage and the bias-add/ReLU block.
import conv_bias_relu_1x1_pkg::*;

interface conv_bias_relu_1x1_if #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  valid_bias_in;
  logic [DATA_WIDTH-1:0] bias_in;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] pxl_in;
  logic [DATA_WIDTH-1:0] pxl_out;
  logic                  valid_out;
  logic                  bias_ready;
  logic                  frame_done;

  modport master (
    output valid_bias_in, bias_in, valid_in, pxl_in,
    input  pxl_out, valid_out, bias_ready, frame_done
  );

  modport slave (
    input  valid_bias_in, bias_in, valid_in, pxl_in,
    output pxl_out, valid_out, bias_ready, frame_done
  );
endinterface

// File: rtl/conv_bias_relu_1x1_bias_buffer.sv
// Per-channel bias store: one write port, one registered read port (RAM-inferable).
module conv_bias_relu_1x1_bias_buffer #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 7
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on the array so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/conv_bias_relu_1x1.sv
// Bias-add with saturation and optional ReLU after the stride-2 1x1 conv.
// Define CONV_RELU_EN to rectify; otherwise the saturated sum passes unmodified.
module conv_bias_relu_1x1
  import conv_bias_relu_1x1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int unsigned CHANNEL_NUM_OUT = CHANNEL_NUM_OUT_DEF,
  parameter int unsigned IMAGE_SIZE      = IMAGE_SIZE_DEF
) (
  input  logic clk,
  input  logic reset,
  conv_bias_relu_1x1_if.slave bus
);

  localparam int unsigned PXL_W = cnt_width(IMAGE_SIZE);
  localparam int unsigned CH_W  = cnt_width(CHANNEL_NUM_OUT);
  localparam logic [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                state_q, state_d;
  logic [CH_W-1:0]       bias_ptr_q;
  logic [PXL_W-1:0]      pxl_cnt_q;
  logic [CH_W-1:0]       ch_cnt_q;
  logic                  bias_ready_q;

  logic                  bias_we_c;
  logic                  accept_c;
  logic                  last_bias_c;
  logic                  last_pxl_c;
  logic                  last_ch_c;

  logic                  s1_valid_q;
  logic                  s1_last_q;
  logic [DATA_WIDTH-1:0] s1_pxl_q;
  logic [DATA_WIDTH-1:0] s1_bias;

  logic [DATA_WIDTH:0]   sum_c;
  logic [DATA_WIDTH-1:0] sat_c;
  logic [DATA_WIDTH-1:0] res_c;

  logic [DATA_WIDTH-1:0] pxl_out_q;
  logic                  valid_out_q;
  logic                  frame_done_q;

  assign last_bias_c = (bias_ptr_q == CH_W'(CHANNEL_NUM_OUT - 1));
  assign last_pxl_c  = (pxl_cnt_q  == PXL_W'(IMAGE_SIZE - 1));
  assign last_ch_c   = (ch_cnt_q   == CH_W'(CHANNEL_NUM_OUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  // LOAD accepts only bias words; RUN accepts only pixels.
  always_comb begin
    state_d   = state_q;
    bias_we_c = 1'b0;
    accept_c  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        bias_we_c = bus.valid_bias_in;
        if (bus.valid_bias_in && last_bias_c) state_d = ST_RUN;
      end
      ST_RUN:  accept_c = bus.valid_in;
      default: state_d = ST_LOAD;
    endcase
  end

  // Bias pointer and pixel/channel position; frozen between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      bias_ptr_q   <= '0;
      pxl_cnt_q    <= '0;
      ch_cnt_q     <= '0;
      bias_ready_q <= 1'b0;
    end else begin
      bias_ready_q <= (state_d == ST_RUN);
      if (bias_we_c) bias_ptr_q <= last_bias_c ? '0 : bias_ptr_q + CH_W'(1);
      if (accept_c) begin
        if (last_pxl_c) begin
          pxl_cnt_q <= '0;
          ch_cnt_q  <= last_ch_c ? '0 : ch_cnt_q + CH_W'(1);
        end else begin
          pxl_cnt_q <= pxl_cnt_q + PXL_W'(1);
        end
      end
    end
  end

  conv_bias_relu_1x1_bias_buffer #(
    .DEPTH (CHANNEL_NUM_OUT),
    .WIDTH (DATA_WIDTH),
    .AW    (CH_W)
  ) u_bias_buffer (
    .clk     (clk),
    .wr_en   (bias_we_c),
    .wr_addr (bias_ptr_q),
    .wr_data (bus.bias_in),
    .rd_en   (accept_c),
    .rd_addr (ch_cnt_q),
    .rd_data (s1_bias)
  );

  // Stage 1: pixel and last-of-frame flag alongside the synchronous bias read.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_pxl_q   <= '0;
    end else begin
      s1_valid_q <= accept_c;
      s1_last_q  <= accept_c && last_pxl_c && last_ch_c;
      if (accept_c) s1_pxl_q <= bus.pxl_in;
    end
  end

  // Sign-extended add; overflow shows as disagreement of the top two bits.
  always_comb begin
    sum_c = {s1_pxl_q[DATA_WIDTH-1], s1_pxl_q} + {s1_bias[DATA_WIDTH-1], s1_bias};
    sat_c = sum_c[DATA_WIDTH-1:0];
    if (sum_c[DATA_WIDTH] != sum_c[DATA_WIDTH-1]) sat_c = sum_c[DATA_WIDTH] ? MIN_V : MAX_V;
`ifdef CONV_RELU_EN
    res_c = sat_c[DATA_WIDTH-1] ? '0 : sat_c;
`else
    res_c = sat_c;
`endif
  end

  // Stage 2: output register; data holds while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pxl_out_q    <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      valid_out_q  <= s1_valid_q;
      frame_done_q <= s1_valid_q && s1_last_q;
      if (s1_valid_q) pxl_out_q <= res_c;
    end
  end

  assign bus.pxl_out    = pxl_out_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.bias_ready = bias_ready_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_bias_relu_1x1.sv
// Directed bench for conv_bias_relu_1x1 on a reduced 4-channel x 8-pixel frame.
module tb_conv_bias_relu_1x1;

  localparam int unsigned DW  = 32;
  localparam int unsigned CH  = 4;
  localparam int unsigned IMG = 8;
  localparam int unsigned FRAME = CH * IMG;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] bias_tbl [CH];
  logic [31:0] exp_q[$];
  logic [31:0] out_q[$];
  logic [31:0] ref_q[$];
  int          in_cyc_q[$];
  int          out_cyc_q[$];
  bit          out_fd_q[$];
  int          fd_cnt = 0;

  conv_bias_relu_1x1_if #(.DATA_WIDTH(DW)) bus ();

  conv_bias_relu_1x1 #(
    .DATA_WIDTH      (DW),
    .CHANNEL_NUM_OUT (CH),
    .IMAGE_SIZE      (IMG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output capture on the falling edge.
  always @(negedge clk) begin
    if (bus.valid_out) begin
      out_q.push_back(bus.pxl_out);
      out_cyc_q.push_back(cyc);
      out_fd_q.push_back(bus.frame_done);
    end
    if (bus.frame_done) fd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [31:0] model(input logic [31:0] p, input logic [31:0] b);
    longint s;
    s = longint'($signed(p)) + longint'($signed(b));
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[31:0];
  endfunction

  function automatic logic [31:0] pix_val(input int k);
    if (k % 5 == 0) return 32'h7FFF_FF00;
    if (k % 7 == 0) return 32'h8000_0010;
    return 32'(k * 1000 - 20000);
  endfunction

  task automatic clear_capture();
    out_q.delete(); out_cyc_q.delete(); out_fd_q.delete();
    exp_q.delete(); in_cyc_q.delete();
    fd_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.valid_in = 1'b0; bus.valid_bias_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_biases();
    for (int c = 0; c < int'(CH); c++) begin
      @(negedge clk);
      bus.valid_bias_in = 1'b1; bus.bias_in = bias_tbl[c];
    end
    @(negedge clk);
    bus.valid_bias_in = 1'b0;
  endtask

  // mode 0: pix_val stream, mode 1: constant 10; gaps inserts random idle cycles.
  task automatic feed(input int n, input bit gaps, input int mode);
    int ch;
    logic [31:0] v;
    for (int k = 0; k < n; k++) begin
      ch = (k / int'(IMG)) % int'(CH);
      v  = (mode == 1) ? 32'd10 : pix_val(k);
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          @(negedge clk);
          bus.valid_in = 1'b0; bus.pxl_in = 32'hDEAD_BEEF;
        end
      end
      @(negedge clk);
      bus.valid_in = 1'b1; bus.pxl_in = v;
      in_cyc_q.push_back(cyc);
      exp_q.push_back(model(v, bias_tbl[ch]));
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (bus.pxl_out !== 32'h0) begin n_fail++; $display("FAIL rst_pxl_out got %h want 0", bus.pxl_out); end
    n_tests++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid_out got %b want 0", bus.valid_out); end
    n_tests++; if (bus.bias_ready !== 1'b0) begin n_fail++; $display("FAIL rst_bias_ready got %b want 0", bus.bias_ready); end
    n_tests++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done got %b want 0", bus.frame_done); end
  endtask

  task automatic test_load();
    clear_capture();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.valid_in = 1'b1; bus.pxl_in = 32'd55;
    end
    @(negedge clk); bus.valid_in = 1'b0;
    drain();
    n_tests++; if (out_q.size() != 0) begin n_fail++; $display("FAIL load_ignore_valid_in got %0d outputs want 0", out_q.size()); end
    bias_tbl = '{32'd0, 32'd1, 32'd2, 32'd3};
    for (int c = 0; c < int'(CH); c++) begin
      if (c == 2) begin
        @(negedge clk); bus.valid_bias_in = 1'b0;
      end
      @(negedge clk);
      bus.valid_bias_in = 1'b1; bus.bias_in = bias_tbl[c];
      if (c == int'(CH) - 1) begin
        n_tests++; if (bus.bias_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_early got %b want 0", bus.bias_ready); end
      end
    end
    @(negedge clk); bus.valid_bias_in = 1'b0;
    n_tests++; if (bus.bias_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready got %b want 1", bus.bias_ready); end
  endtask

  task automatic test_frame_basic();
    clear_capture();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.valid_bias_in = 1'b1; bus.bias_in = 32'h1234_5678;
    end
    @(negedge clk); bus.valid_bias_in = 1'b0;
    drain();
    n_tests++; if (out_q.size() != 0) begin n_fail++; $display("FAIL run_ignore_bias got %0d outputs want 0", out_q.size()); end
    clear_capture();
    feed(FRAME, 1'b0, 1);
    drain();
    n_tests++; if (out_q.size() != FRAME) begin n_fail++; $display("FAIL frame_count got %0d want %0d", out_q.size(), FRAME); end
    for (int i = 0; i < out_q.size() && i < int'(FRAME); i++) begin
      n_tests++;
      if (out_q[i] !== 32'(10 + i / int'(IMG))) begin n_fail++; $display("FAIL frame_val[%0d] got %h want %h", i, out_q[i], 32'(10 + i / int'(IMG))); end
      n_tests++;
      if (out_cyc_q[i] - in_cyc_q[i] != 2) begin n_fail++; $display("FAIL frame_latency[%0d] got %0d want 2", i, out_cyc_q[i] - in_cyc_q[i]); end
      n_tests++;
      if (out_fd_q[i] !== (i == int'(FRAME) - 1)) begin n_fail++; $display("FAIL frame_done_pos[%0d] got %b", i, out_fd_q[i]); end
    end
    n_tests++; if (fd_cnt != 1) begin n_fail++; $display("FAIL frame_done_count got %0d want 1", fd_cnt); end
    n_tests++; if (bus.pxl_out !== 32'd13) begin n_fail++; $display("FAIL hold_pxl_out got %h want 0000000d", bus.pxl_out); end
    n_tests++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL hold_valid_out got %b want 0", bus.valid_out); end
  endtask

  task automatic test_gaps();
    do_reset();
    bias_tbl = '{32'hFFFF_FA24, 32'd7, 32'h7FFF_FFF0, 32'h8000_0005};
    load_biases();
    clear_capture();
    feed(2 * FRAME, 1'b0, 0);
    drain();
    ref_q = out_q;
    n_tests++; if (fd_cnt != 2) begin n_fail++; $display("FAIL gapless_frame_done got %0d want 2", fd_cnt); end
    clear_capture();
    feed(2 * FRAME, 1'b1, 0);
    drain();
    n_tests++; if (out_q.size() != 2 * FRAME) begin n_fail++; $display("FAIL gaps_count got %0d want %0d", out_q.size(), 2 * FRAME); end
    for (int i = 0; i < out_q.size() && i < ref_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== ref_q[i]) begin n_fail++; $display("FAIL gaps_vs_gapless[%0d] got %h want %h", i, out_q[i], ref_q[i]); end
      n_tests++;
      if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL gaps_val[%0d] got %h want %h", i, out_q[i], exp_q[i]); end
      n_tests++;
      if (out_cyc_q[i] - in_cyc_q[i] != 2) begin n_fail++; $display("FAIL gaps_latency[%0d] got %0d want 2", i, out_cyc_q[i] - in_cyc_q[i]); end
    end
    n_tests++; if (fd_cnt != 2) begin n_fail++; $display("FAIL gaps_frame_done got %0d want 2", fd_cnt); end
  endtask

  task automatic test_reset_midframe();
    clear_capture();
    for (int i = 0; i <= 29; i++) begin
      @(negedge clk);
      if (i == 29) begin
        n_tests++; if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1", bus.valid_out); end
        reset = 1'b1;
      end
      bus.valid_in = 1'b1; bus.pxl_in = pix_val(i);
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    n_tests++; if (bus.pxl_out !== 32'h0) begin n_fail++; $display("FAIL mid_rst_pxl_out got %h want 0", bus.pxl_out); end
    n_tests++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid_out got %b want 0", bus.valid_out); end
    n_tests++; if (bus.bias_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_bias_ready got %b want 0", bus.bias_ready); end
    reset = 1'b0;
    clear_capture();
    drain();
    n_tests++; if (out_q.size() != 0) begin n_fail++; $display("FAIL mid_flush got %0d outputs want 0", out_q.size()); end
    bias_tbl = '{32'd100, 32'd200, 32'd300, 32'd400};
    load_biases();
    n_tests++; if (bus.bias_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reload_ready got %b want 1", bus.bias_ready); end
    clear_capture();
    feed(FRAME, 1'b0, 0);
    drain();
    n_tests++; if (out_q.size() != FRAME) begin n_fail++; $display("FAIL mid_count got %0d want %0d", out_q.size(), FRAME); end
    if (out_q.size() > 0) begin
      n_tests++; if (out_q[0] !== 32'h7FFF_FF64) begin n_fail++; $display("FAIL mid_first got %h want 7fffff64", out_q[0]); end
    end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_val[%0d] got %h want %h", i, out_q[i], exp_q[i]); end
    end
    n_tests++; if (fd_cnt != 1) begin n_fail++; $display("FAIL mid_frame_done got %0d want 1", fd_cnt); end
  endtask

  task automatic test_saturation();
    logic [31:0] sb [6];
    logic [31:0] sp [6];
    logic [31:0] se [6];
    sb = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'h7FFF_FFFF, 32'd100};
    sp = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd3,         32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFE2};
`ifdef CONV_RELU_EN
    se = '{32'h7FFF_FFFF, 32'h0,         32'h0,         32'h0,         32'h7FFF_FFFF, 32'd70};
`else
    se = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF, 32'd70};
`endif
    for (int j = 0; j < 6; j++) begin
      do_reset();
      bias_tbl = '{sb[j], 32'd0, 32'd0, 32'd0};
      load_biases();
      clear_capture();
      @(negedge clk); bus.valid_in = 1'b1; bus.pxl_in = sp[j];
      @(negedge clk); bus.valid_in = 1'b0;
      drain();
      n_tests++; if (out_q.size() != 1) begin n_fail++; $display("FAIL sat_count[%0d] got %0d want 1", j, out_q.size()); end
      if (out_q.size() > 0) begin
        n_tests++; if (out_q[0] !== se[j]) begin n_fail++; $display("FAIL sat_val[%0d] got %h want %h", j, out_q[0], se[j]); end
      end
    end
    repeat (3) @(negedge clk);
    n_tests++; if (bus.pxl_out !== se[5]) begin n_fail++; $display("FAIL sat_hold got %h want %h", bus.pxl_out, se[5]); end
  endtask

  initial begin
    reset = 1'b1;
    bus.valid_in = 1'b0; bus.pxl_in = '0;
    bus.valid_bias_in = 1'b0; bus.bias_in = '0;
    test_reset();
    test_load();
    test_frame_basic();
    test_gaps();
    test_reset_midframe();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_bias_relu_1x1.md
CONV_BIAS_RELU_1X1 -- requirements
Module: conv_bias_relu_1x1

Interface
REQ-001 Parameter DATA_WIDTH, 32, sample width, signed two's-complement fixed-point.
REQ-002 Parameter CHANNEL_NUM_OUT, 128, output channels per frame, one bias each.
REQ-003 Parameter IMAGE_SIZE, 1024, pixels per output channel (32x32 after the stride-2 1x1 conv stage).
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 valid_bias_in  input  1  bias word strobe.
REQ-007 bias_in  input  DATA_WIDTH  bias word, channel order 0..CHANNEL_NUM_OUT-1.
REQ-008 valid_in  input  1  conv-stage output strobe (FIFO-aligned stream).
REQ-009 pxl_in  input  DATA_WIDTH  conv result, channel-major: IMAGE_SIZE pixels of ch0, then ch1, ...
REQ-010 pxl_out  output  DATA_WIDTH  biased, optionally rectified pixel.
REQ-011 valid_out  output  1  pxl_out qualifier.
REQ-012 bias_ready  output  1  high once all biases are loaded.
REQ-013 frame_done  output  1  one-cycle pulse with the last valid_out of a frame.

Function
REQ-014 FSM states LOAD, RUN; reset enters LOAD.
REQ-015 LOAD: each valid_bias_in writes bias_in to bias buffer[bias_ptr], bias_ptr increments; after write of entry CHANNEL_NUM_OUT-1 go to RUN next cycle, bias_ready=1.
REQ-016 LOAD: valid_in ignored (no output, counters static).
REQ-017 RUN: valid_bias_in ignored; biases retained across frames.
REQ-018 RUN: each valid_in accepted; pixel counter 0..IMAGE_SIZE-1, wrap increments channel counter 0..CHANNEL_NUM_OUT-1, channel wrap ends frame; counters only advance on valid_in.
REQ-019 Gaps in valid_in of any length allowed; no state change during gaps.
REQ-020 Stage 1 registers pxl_in, bias[channel], last-of-frame flag; stage 2 registers sum; latency exactly 2 cycles valid_in -> valid_out, back-to-back throughput 1/cycle.
REQ-021 Sum computed at DATA_WIDTH+1 bits, saturated to signed DATA_WIDTH range (max 0x7FFFFFFF, min 0x80000000 for 32).
REQ-022 frame_done asserted in same cycle as valid_out of pixel (IMAGE_SIZE-1, CHANNEL_NUM_OUT-1); counters back to 0, next frame starts next valid_in.
REQ-023 pxl_out holds last value when valid_out=0.

Reset
REQ-024 Reset clears: pxl_out=0, valid_out=0, bias_ready=0, frame_done=0, all counters and pointers 0, state LOAD; pipeline flushed.
REQ-025 Reset mid-frame or mid-load discards in-flight data; biases must be reloaded; bias buffer contents need not be cleared.

Configuration
REQ-026 Macro CONV_RELU_EN defined: stage 2 outputs 0 for negative saturated sum, else the sum.
REQ-027 CONV_RELU_EN undefined: stage 2 outputs saturated sum unmodified (linear, for the final classifier conv); latency unchanged.

Structure
REQ-028 Shared package/header holds DATA_WIDTH default, saturation MAX/MIN constants, FSM state encodings, counter widths via $clog2(IMAGE_SIZE), $clog2(CHANNEL_NUM_OUT).
REQ-029 One sub-module bias_buffer: CHANNEL_NUM_OUT x DATA_WIDTH, 1 write port, 1 synchronous read port (distributed/block RAM inferable); rest flat.

Verification
REQ-030 Load biases 0..127 = channel index, frame of pxl_in=10 continuous -> ch c outputs 10+c, 131072 valid_out, each 2 cycles after valid_in, single frame_done on last.
REQ-031 Bias ch0=0x00000001, pxl_in=0x7FFFFFFF -> pxl_out 0x7FFFFFFF; bias ch0=0xFFFFFFFF, pxl_in=0x80000000 with CONV_RELU_EN undefined -> 0x80000000.
REQ-032 Bias ch0=-5, pxl_in=3: with CONV_RELU_EN -> 0; without -> 0xFFFFFFFE.
REQ-033 valid_in before bias_ready and valid_bias_in during RUN -> no valid_out, biases unchanged, frame pixel count unaffected.
REQ-034 Random 1-in-3 valid_in gaps over two frames -> outputs identical to gapless run, frame_done twice.
REQ-035 Reset at pixel 500 of ch3 -> outputs 0 next cycle, bias_ready=0; reload and rerun -> fresh frame starting ch0.
